// File: rtl/rv32i_boot_ctrl.sv
// Boot sequencer for rv32i_cpu: streams a program into memory, releases the CPU, then watches for halt/timeout.
// Optional feature: define BOOT_CHECKSUM_EN to accumulate a modulo-2^32 sum of loaded words on checksum.
module rv32i_boot_ctrl #(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned HALT_CYCLES = 2,
  parameter int unsigned TIMEOUT     = 1000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        abort,
  input  logic [15:0] load_words,
  input  logic        s_valid,
  input  logic [7:0]  s_data,
  output logic        s_ready,
  output logic        cpu_reset,
  input  logic [31:0] cpu_pc,
  input  logic        cpu_mem_we,
  input  logic [31:0] cpu_mem_addr,
  input  logic [31:0] cpu_mem_wdata,
  input  logic [3:0]  cpu_mem_wmask,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wmask,
  output logic [1:0]  state,
  output logic        done,
  output logic        timeout,
  output logic [31:0] halt_pc,
  output logic [31:0] cycle_count,
  output logic [31:0] checksum
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    HALT = 2'd3
  } state_t;

  state_t      cur_state;
  state_t      next_state;

  logic [15:0] load_words_q;
  logic [15:0] word_cnt;
  logic [1:0]  byte_idx;
  logic [23:0] asm_q;
  logic        wr_valid;
  logic [31:0] wr_data;
  logic [31:0] wr_addr;

  logic [31:0] prev_pc;
  logic        pc_valid;
  logic [31:0] stable_cnt;

  logic        start_ok;
  logic        accept;
  logic        last_byte;
  logic        load_done;
  logic        pc_halt;
  logic        run_timeout;

  assign start_ok    = start && !abort && (cur_state == IDLE || cur_state == HALT);
  assign accept      = s_valid && s_ready && (cur_state == LOAD);
  assign last_byte   = accept && (byte_idx == 2'd3) &&
                       (({1'b0, word_cnt} + 17'd1) == {1'b0, load_words_q});
  assign load_done   = wr_valid && (word_cnt == load_words_q);
  assign pc_halt     = (cur_state == RUN) && pc_valid && (stable_cnt == HALT_CYCLES);
  assign run_timeout = (cur_state == RUN) && (cycle_count == 32'(TIMEOUT - 1));
  assign state       = cur_state;

  // cpu_reset is registered from next_state so it always equals (state != RUN)
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cur_state <= IDLE;
      cpu_reset <= 1'b1;
    end else begin
      cur_state <= next_state;
      cpu_reset <= (next_state != RUN);
    end
  end

  always_comb begin
    next_state = cur_state;
    if (abort) begin
      next_state = IDLE;
    end else begin
      case (cur_state)
        IDLE, HALT: if (start) next_state = (load_words != 16'd0) ? LOAD : RUN;
        LOAD:       if (load_done) next_state = RUN;
        RUN:        if (pc_halt || run_timeout) next_state = HALT;
        default:    next_state = IDLE;
      endcase
    end
  end

  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = 32'h0;
    mem_wdata = 32'h0;
    mem_wmask = 4'h0;
    done      = (cur_state == HALT);
    case (cur_state)
      LOAD: begin
        if (wr_valid) begin
          mem_we    = 1'b1;
          mem_addr  = wr_addr;
          mem_wdata = wr_data;
          mem_wmask = 4'hF;
        end
      end
      RUN: begin
        mem_we    = cpu_mem_we;
        mem_addr  = cpu_mem_addr;
        mem_wdata = cpu_mem_wdata;
        mem_wmask = cpu_mem_wmask;
      end
      default: ;
    endcase
  end

  // Byte assembly; lane 3 completes a word which is written on the following cycle
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s_ready      <= 1'b0;
      load_words_q <= 16'h0;
      word_cnt     <= 16'h0;
      byte_idx     <= 2'd0;
      asm_q        <= 24'h0;
      wr_valid     <= 1'b0;
      wr_data      <= 32'h0;
      wr_addr      <= 32'h0;
    end else begin
      wr_valid <= 1'b0;
      if (abort) begin
        s_ready  <= 1'b0;
        byte_idx <= 2'd0;
      end else if (start_ok) begin
        load_words_q <= load_words;
        word_cnt     <= 16'h0;
        byte_idx     <= 2'd0;
        s_ready      <= (load_words != 16'd0);
      end else if (accept) begin
        byte_idx <= byte_idx + 2'd1;
        case (byte_idx)
          2'd0: asm_q[7:0]   <= s_data;
          2'd1: asm_q[15:8]  <= s_data;
          2'd2: asm_q[23:16] <= s_data;
          default: begin
            wr_valid <= 1'b1;
            wr_data  <= {s_data, asm_q};
            wr_addr  <= BASE_ADDR + {14'h0, word_cnt, 2'b00};
            word_cnt <= word_cnt + 16'd1;
          end
        endcase
        if (last_byte) s_ready <= 1'b0;
      end
    end
  end

  // Halt detection: the first RUN cycle only seeds prev_pc
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cycle_count <= 32'h0;
      timeout     <= 1'b0;
      halt_pc     <= 32'h0;
      prev_pc     <= 32'h0;
      pc_valid    <= 1'b0;
      stable_cnt  <= 32'h0;
    end else if (abort) begin
      timeout    <= 1'b0;
      pc_valid   <= 1'b0;
      stable_cnt <= 32'h0;
    end else if (start_ok) begin
      cycle_count <= 32'h0;
      timeout     <= 1'b0;
      pc_valid    <= 1'b0;
      stable_cnt  <= 32'h0;
    end else if (cur_state == RUN) begin
      prev_pc  <= cpu_pc;
      pc_valid <= 1'b1;
      if (pc_valid) stable_cnt <= (cpu_pc == prev_pc) ? stable_cnt + 32'd1 : 32'h0;
      if (next_state == RUN) cycle_count <= cycle_count + 32'd1;
      if (next_state == HALT) begin
        halt_pc <= cpu_pc;
        timeout <= run_timeout && !pc_halt;
      end
    end
  end

`ifdef BOOT_CHECKSUM_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      checksum <= 32'h0;
    end else if (start_ok) begin
      checksum <= 32'h0;
    end else if (cur_state == LOAD && wr_valid) begin
      checksum <= checksum + wr_data;
    end
  end
`else
  assign checksum = 32'h0;
`endif

endmodule

// File: tb/tb_rv32i_boot_ctrl.sv
// Directed testbench for rv32i_boot_ctrl (TIMEOUT=8 so the timeout path is reachable quickly).
module tb_rv32i_boot_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        abort;
  logic [15:0] load_words;
  logic        s_valid;
  logic [7:0]  s_data;
  logic        s_ready;
  logic        cpu_reset;
  logic [31:0] cpu_pc;
  logic        cpu_mem_we;
  logic [31:0] cpu_mem_addr;
  logic [31:0] cpu_mem_wdata;
  logic [3:0]  cpu_mem_wmask;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wmask;
  logic [1:0]  state;
  logic        done;
  logic        timeout;
  logic [31:0] halt_pc;
  logic [31:0] cycle_count;
  logic [31:0] checksum;

  int checks = 0;
  int errors = 0;

  logic [31:0] wr_addr_q[$];
  logic [31:0] wr_data_q[$];
  logic [3:0]  wr_mask_q[$];

`ifdef BOOT_CHECKSUM_EN
  localparam logic [31:0] CSUM_PROG = 32'h00A00582;
  localparam logic [31:0] CSUM_ONE  = 32'hDDCCBBAA;
`else
  localparam logic [31:0] CSUM_PROG = 32'h0;
  localparam logic [31:0] CSUM_ONE  = 32'h0;
`endif

  logic [7:0] prog [8] = '{8'h13, 8'h05, 8'hA0, 8'h00, 8'h6F, 8'h00, 8'h00, 8'h00};

  rv32i_boot_ctrl #(
    .BASE_ADDR  (32'h0000_0000),
    .HALT_CYCLES(2),
    .TIMEOUT    (8)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .abort        (abort),
    .load_words   (load_words),
    .s_valid      (s_valid),
    .s_data       (s_data),
    .s_ready      (s_ready),
    .cpu_reset    (cpu_reset),
    .cpu_pc       (cpu_pc),
    .cpu_mem_we   (cpu_mem_we),
    .cpu_mem_addr (cpu_mem_addr),
    .cpu_mem_wdata(cpu_mem_wdata),
    .cpu_mem_wmask(cpu_mem_wmask),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_wmask    (mem_wmask),
    .state        (state),
    .done         (done),
    .timeout      (timeout),
    .halt_pc      (halt_pc),
    .cycle_count  (cycle_count),
    .checksum     (checksum)
  );

  always #5 clk = ~clk;

  // Logs every loader-side write seen mid-cycle
  always @(negedge clk) begin
    if (mem_we && state == 2'd1) begin
      wr_addr_q.push_back(mem_addr);
      wr_data_q.push_back(mem_wdata);
      wr_mask_q.push_back(mem_wmask);
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
      else begin
        errors++;
        $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
      end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic applyStimulus(input logic [7:0] b);
    int guard;
    guard = 0;
    s_valid = 1'b1;
    s_data  = b;
    while (!s_ready && guard < 20) begin
      tick(1);
      guard++;
    end
    if (guard >= 20) checkOutput("s_ready_wait", {31'h0, s_ready}, 32'd1);
    tick(1);
    s_valid = 1'b0;
  endtask

  task automatic clearLog();
    wr_addr_q.delete();
    wr_data_q.delete();
    wr_mask_q.delete();
  endtask

  task automatic checkTwoWordLog(input string tag);
    checkOutput({tag, "_count"}, 32'(wr_addr_q.size()), 32'd2);
    if (wr_addr_q.size() >= 2) begin
      checkOutput({tag, "_addr0"}, wr_addr_q[0], 32'h0);
      checkOutput({tag, "_data0"}, wr_data_q[0], 32'h00A00513);
      checkOutput({tag, "_mask0"}, {28'h0, wr_mask_q[0]}, 32'hF);
      checkOutput({tag, "_addr1"}, wr_addr_q[1], 32'h4);
      checkOutput({tag, "_data1"}, wr_data_q[1], 32'h0000006F);
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; abort = 1'b0; load_words = 16'h0;
    s_valid = 1'b0; s_data = 8'h0; cpu_pc = 32'h0;
    cpu_mem_we = 1'b0; cpu_mem_addr = 32'h0; cpu_mem_wdata = 32'h0; cpu_mem_wmask = 4'h0;
    tick(2);

    checkOutput("rst_state", {30'h0, state}, 32'd0);
    checkOutput("rst_cpu_reset", {31'h0, cpu_reset}, 32'd1);
    checkOutput("rst_s_ready", {31'h0, s_ready}, 32'd0);
    checkOutput("rst_mem_we", {31'h0, mem_we}, 32'd0);
    checkOutput("rst_done", {31'h0, done}, 32'd0);
    checkOutput("rst_halt_pc", halt_pc, 32'h0);
    checkOutput("rst_cycle_count", cycle_count, 32'h0);
    checkOutput("rst_checksum", checksum, 32'h0);
    reset = 1'b0;
    tick(1);

    // Two-word load streamed back to back, then PC parked at 4
    cpu_pc = 32'h4;
    load_words = 16'd2; start = 1'b1;
    tick(1);
    start = 1'b0;
    checkOutput("t1_state_load", {30'h0, state}, 32'd1);
    checkOutput("t1_s_ready", {31'h0, s_ready}, 32'd1);
    for (int i = 0; i < 8; i++) applyStimulus(prog[i]);
    checkOutput("t1_final_we", {31'h0, mem_we}, 32'd1);
    checkOutput("t1_final_addr", mem_addr, 32'h4);
    checkOutput("t1_ready_low", {31'h0, s_ready}, 32'd0);
    checkOutput("t1_cpu_reset_load", {31'h0, cpu_reset}, 32'd1);
    tick(1);
    checkOutput("t1_state_run", {30'h0, state}, 32'd2);
    checkOutput("t1_cpu_reset_run", {31'h0, cpu_reset}, 32'd0);
    checkTwoWordLog("t1");
    tick(3);
    checkOutput("t1_still_run", {30'h0, state}, 32'd2);
    tick(1);
    checkOutput("t1_state_halt", {30'h0, state}, 32'd3);
    checkOutput("t1_done", {31'h0, done}, 32'd1);
    checkOutput("t1_halt_pc", halt_pc, 32'h4);
    checkOutput("t1_timeout", {31'h0, timeout}, 32'd0);
    checkOutput("t1_cycle_count", cycle_count, 32'd3);
    checkOutput("t1_checksum", checksum, CSUM_PROG);
    checkOutput("t1_cpu_reset_halt", {31'h0, cpu_reset}, 32'd1);

    // Same load with s_valid dropping every other cycle, restarted from HALT
    clearLog();
    cpu_pc = 32'h8;
    start = 1'b1;
    tick(1);
    start = 1'b0;
    checkOutput("t2_state_load", {30'h0, state}, 32'd1);
    checkOutput("t2_done_clear", {31'h0, done}, 32'd0);
    checkOutput("t2_cycle_clear", cycle_count, 32'h0);
    checkOutput("t2_checksum_clear", checksum, 32'h0);
    for (int i = 0; i < 8; i++) begin
      applyStimulus(prog[i]);
      if (i != 7) tick(1);
    end
    tick(1);
    checkOutput("t2_state_run", {30'h0, state}, 32'd2);
    checkTwoWordLog("t2");
    tick(4);
    checkOutput("t2_state_halt", {30'h0, state}, 32'd3);
    checkOutput("t2_halt_pc", halt_pc, 32'h8);
    checkOutput("t2_checksum", checksum, CSUM_PROG);

    // Zero-word start goes straight to RUN; CPU store passes through, start ignored, then timeout
    clearLog();
    cpu_mem_we = 1'b1; cpu_mem_addr = 32'h200; cpu_mem_wdata = 32'h12345678; cpu_mem_wmask = 4'hF;
    #1;
    checkOutput("halt_cpu_store_blocked", {31'h0, mem_we}, 32'd0);
    cpu_mem_we = 1'b0;
    load_words = 16'd0; start = 1'b1;
    tick(1);
    start = 1'b0;
    checkOutput("t3_state_run", {30'h0, state}, 32'd2);
    checkOutput("t3_cpu_reset", {31'h0, cpu_reset}, 32'd0);
    checkOutput("t3_no_loader_we", {31'h0, mem_we}, 32'd0);
    checkOutput("t3_cycle_count0", cycle_count, 32'd0);
    cpu_pc = 32'h10;
    cpu_mem_we = 1'b1; cpu_mem_addr = 32'h100; cpu_mem_wdata = 32'hDEADBEEF; cpu_mem_wmask = 4'hF;
    load_words = 16'd5; start = 1'b1;
    #1;
    checkOutput("t6_mem_we", {31'h0, mem_we}, 32'd1);
    checkOutput("t6_mem_addr", mem_addr, 32'h100);
    checkOutput("t6_mem_wdata", mem_wdata, 32'hDEADBEEF);
    checkOutput("t6_mem_wmask", {28'h0, mem_wmask}, 32'hF);
    tick(1);
    start = 1'b0; cpu_mem_we = 1'b0;
    cpu_pc = 32'h14;
    checkOutput("t6_start_ignored", {30'h0, state}, 32'd2);
    checkOutput("t6_s_ready", {31'h0, s_ready}, 32'd0);
    checkOutput("t6_cycle_count1", cycle_count, 32'd1);
    for (int i = 2; i < 8; i++) begin
      tick(1);
      cpu_pc = 32'h10 + 32'(4 * i);
    end
    checkOutput("t4_still_run", {30'h0, state}, 32'd2);
    checkOutput("t4_cycle_count7", cycle_count, 32'd7);
    tick(1);
    checkOutput("t4_state_halt", {30'h0, state}, 32'd3);
    checkOutput("t4_timeout", {31'h0, timeout}, 32'd1);
    checkOutput("t4_cycle_count", cycle_count, 32'd7);
    checkOutput("t4_halt_pc", halt_pc, 32'h2C);
    checkOutput("t4_done", {31'h0, done}, 32'd1);
    checkOutput("t3_loader_log", 32'(wr_addr_q.size()), 32'd0);

    // Abort after 5 bytes of a 3-word load
    clearLog();
    load_words = 16'd3; start = 1'b1;
    tick(1);
    start = 1'b0;
    checkOutput("t5_timeout_clear", {31'h0, timeout}, 32'd0);
    applyStimulus(8'h11); applyStimulus(8'h22); applyStimulus(8'h33);
    applyStimulus(8'h44); applyStimulus(8'h55);
    abort = 1'b1;
    tick(1);
    abort = 1'b0;
    checkOutput("t5_state_idle", {30'h0, state}, 32'd0);
    checkOutput("t5_s_ready", {31'h0, s_ready}, 32'd0);
    checkOutput("t5_cpu_reset", {31'h0, cpu_reset}, 32'd1);
    checkOutput("t5_done", {31'h0, done}, 32'd0);
    tick(2);
    checkOutput("t5_write_count", 32'(wr_addr_q.size()), 32'd1);
    if (wr_addr_q.size() >= 1) begin
      checkOutput("t5_addr0", wr_addr_q[0], 32'h0);
      checkOutput("t5_data0", wr_data_q[0], 32'h44332211);
    end

    // abort beats start in the same cycle
    start = 1'b1; abort = 1'b1; load_words = 16'd1;
    tick(1);
    start = 1'b0; abort = 1'b0;
    checkOutput("abort_over_start", {30'h0, state}, 32'd0);

    // Fresh start reloads from the base address
    clearLog();
    start = 1'b1;
    tick(1);
    start = 1'b0;
    applyStimulus(8'hAA); applyStimulus(8'hBB); applyStimulus(8'hCC); applyStimulus(8'hDD);
    tick(1);
    checkOutput("reload_state_run", {30'h0, state}, 32'd2);
    checkOutput("reload_count", 32'(wr_addr_q.size()), 32'd1);
    if (wr_addr_q.size() >= 1) begin
      checkOutput("reload_addr", wr_addr_q[0], 32'h0);
      checkOutput("reload_data", wr_data_q[0], 32'hDDCCBBAA);
    end
    checkOutput("reload_checksum", checksum, CSUM_ONE);
    abort = 1'b1;
    tick(1);
    abort = 1'b0;
    checkOutput("run_abort_state", {30'h0, state}, 32'd0);
    checkOutput("run_abort_cpu_reset", {31'h0, cpu_reset}, 32'd1);

    // Asynchronous reset during the final write cycle of a load
    clearLog();
    load_words = 16'd1; start = 1'b1;
    tick(1);
    start = 1'b0;
    applyStimulus(8'h01); applyStimulus(8'h02); applyStimulus(8'h03); applyStimulus(8'h04);
    checkOutput("areset_pre_we", {31'h0, mem_we}, 32'd1);
    reset = 1'b1;
    #1;
    checkOutput("areset_mem_we", {31'h0, mem_we}, 32'd0);
    checkOutput("areset_state", {30'h0, state}, 32'd0);
    checkOutput("areset_cpu_reset", {31'h0, cpu_reset}, 32'd1);
    checkOutput("areset_halt_pc", halt_pc, 32'h0);
    checkOutput("areset_checksum", checksum, 32'h0);
    tick(1);
    reset = 1'b0;
    tick(1);
    checkOutput("areset_no_write", 32'(wr_addr_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
